// File: rtl/layer_draw_scheduler.sv
// Per-frame layer sequencer: owns the sprite drawer and issues one draw per enabled
// layer, in ascending index order, on every rising edge of frameTick.
module layer_draw_scheduler #(
  parameter int NUM_LAYERS  = 4,
  parameter int ROMID_W     = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 9,
  parameter int ACK_TIMEOUT = 15,
  parameter int LAYER_W     = $clog2(NUM_LAYERS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frameTick,
  input  logic               cfgWrite,
  input  logic [LAYER_W-1:0] cfgLayer,
  input  logic               cfgEnable,
  input  logic [ROMID_W-1:0] cfgROMId,
  input  logic [X_W-1:0]     cfgX,
  input  logic [Y_W-1:0]     cfgY,
  input  logic               drawerReady,
  output logic               draw,
  output logic [X_W-1:0]     xOrigin,
  output logic [Y_W-1:0]     yOrigin,
  output logic [ROMID_W-1:0] ROMId,
  output logic               busy,
  output logic               frameDone,
  output logic               ackError,
  output logic [7:0]         overrunCount
);

  typedef struct packed {
    logic               en;
    logic [ROMID_W-1:0] rom_id;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
  } entry_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  entry_t             pending     [NUM_LAYERS];
  entry_t             pending_nxt [NUM_LAYERS];
  entry_t             active      [NUM_LAYERS];
  entry_t             cur;
  logic [LAYER_W-1:0] idx;
  logic [7:0]         ack_cnt;
  logic               tick_q;
  logic               tick_edge;
  logic               last_idx;
  logic               cfg_hit;
  logic               commit;
  logic               issue;
  logic               advance;
  logic               timeout;

  // tick_q resets low, so a tick already high when reset releases is seen as an edge.
  assign tick_edge = frameTick & ~tick_q;
  assign last_idx  = (idx == LAYER_W'(NUM_LAYERS - 1));
  assign cfg_hit   = cfgWrite && ({1'b0, cfgLayer} < (LAYER_W + 1)'(NUM_LAYERS));
  assign cur       = active[idx];
  assign busy      = (state != IDLE);
  assign frameDone = (state == DONE);

  // The pending view including this cycle's write; the frame commit copies this view.
  always_comb begin
    pending_nxt = pending;
    if (cfg_hit) begin
      pending_nxt[cfgLayer] = '{en: cfgEnable, rom_id: cfgROMId, x: cfgX, y: cfgY};
    end
  end

  // NOTE: the layer tables are reset on purpose: "all entries disabled" is visible
  // behaviour, since a frame started straight after reset must issue no draws.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '{default: '0};
      active  <= '{default: '0};
    end else begin
      pending <= pending_nxt;
      if (commit) begin
        active <= pending_nxt;
      end
    end
  end

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values,
  // independent of statement or block order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    state_nxt = state;
    commit    = 1'b0;
    issue     = 1'b0;
    advance   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (tick_edge) begin
          commit    = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (cur.en) begin
          state_nxt = ISSUE;
        end else if (last_idx) begin
          state_nxt = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      ISSUE: begin
        if (drawerReady) begin
          issue     = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!drawerReady) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
          // The drawer never acknowledged: flag it and move on as if the layer completed.
          timeout   = 1'b1;
          advance   = ~last_idx;
          state_nxt = last_idx ? DONE : SCAN;
        end
      end
      WAIT_DONE: begin
        if (drawerReady) begin
          advance   = ~last_idx;
          state_nxt = last_idx ? DONE : SCAN;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_q       <= 1'b0;
      idx          <= '0;
      ack_cnt      <= '0;
      draw         <= 1'b0;
      xOrigin      <= '0;
      yOrigin      <= '0;
      ROMId        <= '0;
      ackError     <= 1'b0;
      overrunCount <= '0;
    end else begin
      tick_q <= frameTick;
      draw   <= issue;

      if (commit) begin
        idx <= '0;
      end else if (advance) begin
        idx <= idx + LAYER_W'(1);
      end

      // Origin and ROM id change only on issue, so they hold between draws and after the frame.
      if (issue) begin
        ack_cnt <= '0;
        xOrigin <= cur.x;
        yOrigin <= cur.y;
        ROMId   <= cur.rom_id;
      end else if (state == WAIT_ACK && drawerReady) begin
        ack_cnt <= ack_cnt + 8'd1;
      end

      if (timeout) begin
        ackError <= 1'b1;
      end

      if (tick_edge && state != IDLE && overrunCount != 8'hFF) begin
        overrunCount <= overrunCount + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_layer_draw_scheduler.sv
// Self-checking bench for layer_draw_scheduler: a drawer model plus a reference model
// that turns the pending table into the expected per-frame draw list.
module tb_layer_draw_scheduler;

  localparam int NUM_LAYERS  = 4;
  localparam int ROMID_W     = 4;
  localparam int X_W         = 8;
  localparam int Y_W         = 9;
  localparam int ACK_TIMEOUT = 15;
  localparam int LAYER_W     = $clog2(NUM_LAYERS);

  logic               clock = 1'b0;
  logic               reset;
  logic               frameTick;
  logic               cfgWrite;
  logic [LAYER_W-1:0] cfgLayer;
  logic               cfgEnable;
  logic [ROMID_W-1:0] cfgROMId;
  logic [X_W-1:0]     cfgX;
  logic [Y_W-1:0]     cfgY;
  logic               drawerReady;
  logic               draw;
  logic [X_W-1:0]     xOrigin;
  logic [Y_W-1:0]     yOrigin;
  logic [ROMID_W-1:0] ROMId;
  logic               busy;
  logic               frameDone;
  logic               ackError;
  logic [7:0]         overrunCount;

  layer_draw_scheduler #(
    .NUM_LAYERS (NUM_LAYERS),
    .ROMID_W    (ROMID_W),
    .X_W        (X_W),
    .Y_W        (Y_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frameTick   (frameTick),
    .cfgWrite    (cfgWrite),
    .cfgLayer    (cfgLayer),
    .cfgEnable   (cfgEnable),
    .cfgROMId    (cfgROMId),
    .cfgX        (cfgX),
    .cfgY        (cfgY),
    .drawerReady (drawerReady),
    .draw        (draw),
    .xOrigin     (xOrigin),
    .yOrigin     (yOrigin),
    .ROMId       (ROMId),
    .busy        (busy),
    .frameDone   (frameDone),
    .ackError    (ackError),
    .overrunCount(overrunCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit en;
    int rom;
    int x;
    int y;
  } layer_t;

  layer_t m_pend [NUM_LAYERS];
  layer_t exp_q  [$];
  int     n_checks;
  int     n_errors;
  int     done_count;
  int     exp_frames;
  int     draw_count;
  int     m_overrun;
  bit     m_ack_err;
  bit     stuck;
  int     busy_len;
  int     ack_delay;
  time    t_ack;
  time    t_done;
  time    t_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_draw"},     32'(draw), 0);
    check({tag, "_x"},        32'(xOrigin), 0);
    check({tag, "_y"},        32'(yOrigin), 0);
    check({tag, "_rom"},      32'(ROMId), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_done"},     32'(frameDone), 0);
    check({tag, "_ackerr"},   32'(ackError), 0);
    check({tag, "_overrun"},  32'(overrunCount), 0);
  endtask

  task automatic cfg_write(input int layer, input int en, input int rom, input int x, input int y);
    @(negedge clock);
    cfgWrite  = 1'b1;
    cfgLayer  = LAYER_W'(layer);
    cfgEnable = (en != 0);
    cfgROMId  = ROMID_W'(rom);
    cfgX      = X_W'(x);
    cfgY      = Y_W'(y);
    if (layer < NUM_LAYERS) m_pend[layer] = '{en != 0, rom, x, y};
    @(negedge clock);
    cfgWrite = 1'b0;
  endtask

  // The expected draw list of a frame is the enabled pending entries, lowest index first.
  task automatic start_frame();
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (m_pend[i].en) exp_q.push_back(m_pend[i]);
    end
    exp_frames++;
    @(negedge clock);
    frameTick = 1'b1;
    t_tick    = $time;
    @(negedge clock);
    frameTick = 1'b0;
  endtask

  // A tick edge while a frame is in flight is dropped and counted.
  task automatic tick_pulse();
    @(negedge clock);
    frameTick = 1'b1;
    @(negedge clock);
    frameTick = 1'b0;
    if (m_overrun < 255) m_overrun++;
  endtask

  task automatic wait_frame(input int budget);
    int n;
    n = 0;
    while (done_count < exp_frames && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("frame_count", 32'(done_count), 32'(exp_frames));
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_draw(input int budget);
    int n;
    n = 0;
    while (!draw && n < budget) begin
      @(negedge clock);
      n++;
    end
    check("draw_seen", 32'(draw), 1);
  endtask

  // Drawer model: acknowledges a draw by dropping ready, stays busy busy_len cycles.
  initial begin
    drawerReady = 1'b1;
    forever begin
      @(negedge clock);
      if (reset && draw) begin
        check("ready_at_draw", 32'(drawerReady), 1);
        if (!stuck) begin
          repeat (ack_delay) @(negedge clock);
          drawerReady = 1'b0;
          t_ack       = $time;
          repeat (busy_len) @(negedge clock);
          drawerReady = 1'b1;
        end
      end
    end
  end

  // Scoreboard: every draw must match the head of the expected list.
  initial begin
    layer_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (draw) begin
          draw_count++;
          check("draw_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("draw_rom", 32'(ROMId), e.rom);
            check("draw_x", 32'(xOrigin), e.x);
            check("draw_y", 32'(yOrigin), e.y);
          end
        end
        if (frameDone) begin
          t_done = $time;
          done_count++;
          check("frame_leftover", 32'(exp_q.size()), 0);
          check("busy_at_done", 32'(busy), 1);
          @(negedge clock);
          check("busy_after_done", 32'(busy), 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset     = 1'b0;
    frameTick = 1'b0;
    cfgWrite  = 1'b0;
    cfgLayer  = '0;
    cfgEnable = 1'b0;
    cfgROMId  = '0;
    cfgX      = '0;
    cfgY      = '0;
    stuck     = 1'b0;
    busy_len  = 40;
    ack_delay = 0;
    for (int i = 0; i < NUM_LAYERS; i++) m_pend[i] = '{0, 0, 0, 0};

    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b1;

    // Two enabled layers drawn in index order.
    cfg_write(0, 1, 3, 100, 20);
    cfg_write(1, 1, 1, 60, 150);
    start_frame();
    wait_frame(400);
    check("t1_draws", 32'(draw_count), 2);
    check("t1_hold_rom", 32'(ROMId), 1);
    check("t1_hold_x", 32'(xOrigin), 60);
    check("t1_hold_y", 32'(yOrigin), 150);

    // Only layer 2: after the drawer finishes, layer 3 is scanned, then DONE.
    cfg_write(0, 0, 0, 0, 0);
    cfg_write(1, 0, 0, 0, 0);
    cfg_write(2, 1, 7, 33, 400);
    start_frame();
    wait_frame(400);
    check("t2_draws", 32'(draw_count), 3);
    check("t2_done_latency", 32'((t_done - t_ack) / 10), 32'(busy_len + (NUM_LAYERS - 1 - 2) + 1));

    // Nothing enabled: tick cycle, one SCAN per entry, then the DONE cycle.
    cfg_write(2, 0, 0, 0, 0);
    start_frame();
    wait_frame(100);
    check("t3_draws", 32'(draw_count), 3);
    check("t3_done_latency", 32'((t_done - t_tick) / 10), 32'(NUM_LAYERS + 1));

    // Ticks during a long frame are dropped; the counter saturates.
    for (int i = 0; i < NUM_LAYERS; i++) cfg_write(i, 1, i + 8, 10 * i + 5, 100 + i);
    busy_len = 250;
    start_frame();
    repeat (4) @(negedge clock);
    for (int p = 1; p <= 300; p++) begin
      tick_pulse();
      if (p == 10 || p == 255 || p == 256) check("t4_overrun", 32'(overrunCount), 32'(m_overrun));
    end
    check("t4_overrun_sat", 32'(overrunCount), 255);
    wait_frame(2000);
    check("t4_draws", 32'(draw_count), 7);
    busy_len = 40;

    // Drawer never drops ready: timeout after ACK_TIMEOUT cycles, next layer still drawn.
    cfg_write(0, 1, 5, 10, 11);
    cfg_write(1, 1, 6, 12, 13);
    cfg_write(2, 0, 0, 0, 0);
    cfg_write(3, 0, 0, 0, 0);
    stuck = 1'b1;
    start_frame();
    wait_draw(20);
    repeat (ACK_TIMEOUT - 1) @(negedge clock);
    check("t5_ackerr_before", 32'(ackError), 0);
    @(negedge clock);
    check("t5_ackerr_set", 32'(ackError), 1);
    m_ack_err = 1'b1;
    wait_frame(200);
    stuck = 1'b0;
    check("t5_draws", 32'(draw_count), 9);
    check("t5_ackerr_sticky", 32'(ackError), 32'(m_ack_err));

    // Randomized tables and drawer timing.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        cfg_write(i, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255),
                  $urandom_range(0, 511));
      end
      busy_len  = $urandom_range(1, 30);
      ack_delay = $urandom_range(0, 4);
      start_frame();
      wait_frame(600);
    end
    ack_delay = 0;
    busy_len  = 40;
    check("rand_ackerr", 32'(ackError), 32'(m_ack_err));
    check("rand_overrun", 32'(overrunCount), 32'(m_overrun));

    // Mid-frame config write only takes effect on the following frame.
    cfg_write(0, 1, 2, 1, 2);
    cfg_write(1, 1, 4, 3, 4);
    cfg_write(2, 0, 0, 0, 0);
    cfg_write(3, 0, 0, 0, 0);
    start_frame();
    wait_draw(20);
    cfg_write(1, 1, 9, 77, 300);
    wait_frame(400);
    check("t6_old_x", 32'(xOrigin), 3);
    check("t6_old_rom", 32'(ROMId), 4);
    start_frame();
    wait_frame(400);
    check("t6_new_x", 32'(xOrigin), 77);
    check("t6_new_rom", 32'(ROMId), 9);

    // Reset while the drawer is busy (WAIT_DONE) clears everything at once.
    start_frame();
    wait_draw(20);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    exp_frames--;
    for (int i = 0; i < NUM_LAYERS; i++) m_pend[i] = '{0, 0, 0, 0};
    m_overrun = 0;
    m_ack_err = 1'b0;
    repeat (50) @(negedge clock);

    // Tick held high across reset release counts as an edge; the cleared table draws nothing.
    base      = draw_count;
    frameTick = 1'b1;
    exp_frames++;
    @(negedge clock);
    reset  = 1'b1;
    t_tick = $time;
    @(negedge clock);
    frameTick = 1'b0;
    wait_frame(100);
    check("post_reset_draws", 32'(draw_count), 32'(base));
    check("post_reset_latency", 32'((t_done - t_tick) / 10), 32'(NUM_LAYERS + 1));
    check("post_reset_ackerr", 32'(ackError), 32'(m_ack_err));
    check("post_reset_overrun", 32'(overrunCount), 32'(m_overrun));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
